// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that shares one UART tx line and its
// baud generator between NREQ byte requesters. Frames go out LSB-first on the
// ticks returned by the generator; back-to-back frames keep the generator on.
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit before stop.
//
// state | meaning
// IDLE  | line idle high, generator off, accepts a request immediately
// ARM   | generator enabled, waiting for its first tick
// START | start bit (0)
// DATA  | eight data bits, LSB first
// PAR   | even parity bit (parity build only)
// STOP  | stop bit (1); on its tick either chain the next frame or go idle
module uart_tx_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              baud_tick,
  output logic              baud_ena,
  output logic              tx,
  output logic              busy,
  output logic [IDW-1:0]    grant_id
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, ARM, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ARM, START, DATA, STOP} state_t;
`endif

  state_t         state_q, state_d;
  logic [7:0]     shift_q;
  logic [2:0]     bit_cnt_q;
  logic [IDW-1:0] last_q;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] win_idx;
  logic           win_found;
  logic           accept;
  logic [7:0]     win_byte;
`ifdef UART_TX_PARITY_EN
  logic           par_q;
`endif

  // Round-robin search starting just after the most recently granted index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_q) + k) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Accept only while idle or on the stop tick; reset masks the handshake so
  // no accept is issued while rst is held low.
  always_comb begin
    accept    = 1'b0;
    req_ready = '0;
    if (rst && win_found && (state_q == IDLE || (state_q == STOP && baud_tick))) begin
      accept    = 1'b1;
      req_ready = NREQ'(1) << win_idx;
    end
  end

  assign win_byte = req_data[{win_idx, 3'b000} +: 8];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and line/enable outputs.
  always_comb begin
    state_d  = state_q;
    tx       = 1'b1;
    baud_ena = 1'b1;
    busy     = 1'b1;
    case (state_q)
      IDLE: begin
        baud_ena = 1'b0;
        busy     = 1'b0;
        if (accept) state_d = ARM;
      end
      ARM: begin
        if (baud_tick) state_d = START;
      end
      START: begin
        tx = 1'b0;
        if (baud_tick) state_d = DATA;
      end
      DATA: begin
        tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
        if (baud_tick && bit_cnt_q == 3'd7) state_d = PAR;
`else
        if (baud_tick && bit_cnt_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PAR: begin
        tx = par_q;
        if (baud_tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (baud_tick) state_d = accept ? START : IDLE;
      end
      default: begin
        baud_ena = 1'b0;
        busy     = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // Byte latch, grant bookkeeping, shifter and bit counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      last_q    <= IDW'(NREQ - 1);
      grant_id  <= '0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else if (accept) begin
      shift_q  <= win_byte;
      grant_id <= win_idx;
      last_q   <= win_idx;
`ifdef UART_TX_PARITY_EN
      par_q    <= ^win_byte;
`endif
    end else if (state_q == START && baud_tick) begin
      bit_cnt_q <= '0;
    end else if (state_q == DATA && baud_tick) begin
      shift_q   <= {1'b0, shift_q[7:1]};
      bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

endmodule
